// File: rtl/gpu_prefetch_pkg.sv
// gpu_prefetch_pkg
//   Shared definitions for the instruction prefetch slice: FSM state
//   encoding and the queue pointer width derived from the queue depth.
package gpu_prefetch_pkg;

  // state    | meaning
  // ST_IDLE  | no fetch outstanding; issue when running and two slots free
  // ST_REQ   | fetch outstanding, data will be queued on ack
  // ST_STALE | fetch outstanding but flushed by a jump; data dropped on ack
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_STALE = 2'd2
  } pf_state_e;

  // Pointer width for a power-of-two queue; never below one bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/gpu_ins_prefetch_if.sv
// gpu_ins_prefetch_if
//   Bundles the prefetch queue's control, program-RAM fetch bus and
//   instruction-word output bus.
//   master : the prefetch queue (drives fetch_req/addr and the ins_* outputs)
//   slave  : execution controller + program RAM side
interface gpu_ins_prefetch_if
  import gpu_prefetch_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int QDEPTH = 4
);
  localparam int LVL_W = ptr_width(QDEPTH) + 1;

  logic              go;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_new;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic [31:0]       fetch_data;
  logic              insrdy;
  logic [15:0]       ins_data;
  logic [ADDR_W-1:0] ins_pc;
  logic              romold;
  logic [LVL_W-1:0]  q_level;

  modport master (
    input  go, pc_load, pc_new, fetch_ack, fetch_data, romold,
    output fetch_req, fetch_addr, insrdy, ins_data, ins_pc, q_level
  );

  modport slave (
    output go, pc_load, pc_new, fetch_ack, fetch_data, romold,
    input  fetch_req, fetch_addr, insrdy, ins_data, ins_pc, q_level
  );
endinterface

// File: rtl/prefetch_fifo.sv
// prefetch_fifo
//   16-bit circular buffer. Writes 0, 1 or 2 words per cycle (wr_d0_i first),
//   reads one word per cycle, synchronous flush.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   flush_i            : empty the buffer next cycle (wins over write/read)
//   wr_cnt_i           : number of words to write (0..2)
//   wr_d0_i, wr_d1_i   : write data, d0 enters before d1
//   rd_en_i            : pop head (ignored when empty)
//   rd_data_o          : head word, forced to 0 when empty
//   rd_valid_o         : head word valid
//   level_o            : words held
module prefetch_fifo
  import gpu_prefetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [1:0]       wr_cnt_i,
  input  logic [15:0]      wr_d0_i,
  input  logic [15:0]      wr_d1_i,
  input  logic             rd_en_i,
  output logic [15:0]      rd_data_o,
  output logic             rd_valid_o,
  output logic [LVL_W-1:0] level_o
);

  logic [15:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             pop;

  assign rd_valid_o = (level_q != '0);
  assign pop        = rd_en_i && rd_valid_o;
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : 16'h0000;
  assign level_o    = level_q;

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      if (wr_cnt_i != 2'd0) mem_q[wr_ptr_q] <= wr_d0_i;
      if (wr_cnt_i == 2'd2) mem_q[wr_ptr_q + PTR_W'(1)] <= wr_d1_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(wr_cnt_i);
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q  <= level_q + LVL_W'(wr_cnt_i) - LVL_W'(pop);
    end
  end

endmodule

// File: rtl/gpu_ins_prefetch.sv
// gpu_ins_prefetch
//   Instruction prefetch queue. Fetches 32-bit longwords from program RAM,
//   splits them into two 16-bit words (high half first) and presents one
//   word per cycle to the execution controller. A jump (pc_load) flushes the
//   queue; a fetch in flight at the jump is completed and its data dropped.
//   sys_clk, reset : clock, synchronous active-high reset
//   bus (master)   : go/pc_load/pc_new control, fetch_req/addr/ack/data RAM
//                    port, insrdy/ins_data/ins_pc/romold word port, q_level
module gpu_ins_prefetch
  import gpu_prefetch_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int ADDR_W = 24
) (
  input  logic               sys_clk,
  input  logic               reset,
  gpu_ins_prefetch_if.master bus
);

  localparam int LVL_W = ptr_width(QDEPTH) + 1;

  pf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] ins_pc_q, ins_pc_d;
  logic              skip_hi_q, skip_hi_d;

  logic [LVL_W-1:0]  level;
  logic              room2;
  logic              accept;
  logic              pop;
  logic [1:0]        wr_cnt;
  logic [15:0]       wr_d0;
  logic              head_valid;

  // Two free slots are reserved at issue so the ack always fits.
  assign room2  = (level <= LVL_W'(QDEPTH - 2));
  assign accept = (state_q == ST_REQ) && bus.fetch_ack && !bus.pc_load;
  assign pop    = bus.romold && head_valid && !bus.pc_load;
  assign wr_cnt = accept ? (skip_hi_q ? 2'd1 : 2'd2) : 2'd0;
  // After a jump to an odd word the high half precedes the target.
  assign wr_d0  = skip_hi_q ? bus.fetch_data[15:0] : bus.fetch_data[31:16];

  prefetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk_i      (sys_clk),
    .rst_i      (reset),
    .flush_i    (bus.pc_load),
    .wr_cnt_i   (wr_cnt),
    .wr_d0_i    (wr_d0),
    .wr_d1_i    (bus.fetch_data[15:0]),
    .rd_en_i    (pop),
    .rd_data_o  (bus.ins_data),
    .rd_valid_o (head_valid),
    .level_o    (level)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= '0;
      ins_pc_q     <= '0;
      skip_hi_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      ins_pc_q     <= ins_pc_d;
      skip_hi_q    <= skip_hi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.go && room2 && !bus.pc_load) state_d = ST_REQ;
      ST_REQ: begin
        if (bus.fetch_ack)    state_d = ST_IDLE;
        else if (bus.pc_load) state_d = ST_STALE;
      end
      ST_STALE: if (bus.fetch_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    ins_pc_d     = ins_pc_q;
    skip_hi_d    = skip_hi_q;
    if (bus.pc_load) begin
      fetch_addr_d = {bus.pc_new[ADDR_W-1:2], 2'b00};
      ins_pc_d     = {bus.pc_new[ADDR_W-1:1], 1'b0};
      skip_hi_d    = bus.pc_new[1];
    end else begin
      if (accept) begin
        fetch_addr_d = fetch_addr_q + ADDR_W'(4);
        skip_hi_d    = 1'b0;
      end
      if (pop) ins_pc_d = ins_pc_q + ADDR_W'(2);
    end
  end

  assign bus.fetch_req  = (state_q == ST_REQ);
  assign bus.fetch_addr = fetch_addr_q;
  assign bus.ins_pc     = ins_pc_q;
  assign bus.insrdy     = head_valid;
  assign bus.q_level    = level;

endmodule

// File: tb/tb_gpu_ins_prefetch.sv
// tb_gpu_ins_prefetch
//   Directed testbench for gpu_ins_prefetch: reset, basic fetch/pop,
//   odd-word jump, full queue, jump during fetch, push+pop and address wrap,
//   go low with a fetch outstanding.
module tb_gpu_ins_prefetch;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  always #5 sys_clk = ~sys_clk;

  gpu_ins_prefetch_if #(.ADDR_W(24), .QDEPTH(4)) pf_if ();

  gpu_ins_prefetch #(.QDEPTH(4), .ADDR_W(24)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (pf_if.master)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    pf_if.go         = 1'b0;
    pf_if.pc_load    = 1'b0;
    pf_if.pc_new     = '0;
    pf_if.fetch_ack  = 1'b0;
    pf_if.fetch_data = '0;
    pf_if.romold     = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Jump to addr with go=1; returns one cycle later, state IDLE.
  task automatic jump(input logic [23:0] addr);
    pf_if.go      = 1'b1;
    pf_if.pc_load = 1'b1;
    pf_if.pc_new  = addr;
    tick();
    pf_if.pc_load = 1'b0;
  endtask

  task automatic ack(input logic [31:0] data);
    pf_if.fetch_ack  = 1'b1;
    pf_if.fetch_data = data;
    tick();
    pf_if.fetch_ack  = 1'b0;
  endtask

  task automatic pop1();
    pf_if.romold = 1'b1;
    tick();
    pf_if.romold = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pf_if.insrdy !== 1'b0) begin errors++; $display("FAIL reset_insrdy: got %b want 0", pf_if.insrdy); end
    checks++; if (pf_if.ins_data !== 16'h0000) begin errors++; $display("FAIL reset_ins_data: got %h want 0000", pf_if.ins_data); end
    checks++; if (pf_if.ins_pc !== 24'h000000) begin errors++; $display("FAIL reset_ins_pc: got %h want 000000", pf_if.ins_pc); end
    checks++; if (pf_if.fetch_req !== 1'b0) begin errors++; $display("FAIL reset_fetch_req: got %b want 0", pf_if.fetch_req); end
    checks++; if (pf_if.fetch_addr !== 24'h000000) begin errors++; $display("FAIL reset_fetch_addr: got %h want 000000", pf_if.fetch_addr); end
    checks++; if (pf_if.q_level !== 3'd0) begin errors++; $display("FAIL reset_q_level: got %0d want 0", pf_if.q_level); end
  endtask

  task automatic test_basic();
    do_reset();
    jump(24'h000100);
    checks++; if (pf_if.fetch_req !== 1'b0) begin errors++; $display("FAIL basic_no_req_on_load: got %b want 0", pf_if.fetch_req); end
    checks++; if (pf_if.ins_pc !== 24'h000100) begin errors++; $display("FAIL basic_pc_after_load: got %h want 000100", pf_if.ins_pc); end
    tick();
    checks++; if (pf_if.fetch_req !== 1'b1) begin errors++; $display("FAIL basic_req: got %b want 1", pf_if.fetch_req); end
    checks++; if (pf_if.fetch_addr !== 24'h000100) begin errors++; $display("FAIL basic_addr: got %h want 000100", pf_if.fetch_addr); end
    ack(32'h98761234);
    checks++; if (pf_if.insrdy !== 1'b1) begin errors++; $display("FAIL basic_insrdy: got %b want 1", pf_if.insrdy); end
    checks++; if (pf_if.ins_data !== 16'h9876) begin errors++; $display("FAIL basic_hi_word: got %h want 9876", pf_if.ins_data); end
    checks++; if (pf_if.ins_pc !== 24'h000100) begin errors++; $display("FAIL basic_hi_pc: got %h want 000100", pf_if.ins_pc); end
    checks++; if (pf_if.q_level !== 3'd2) begin errors++; $display("FAIL basic_level2: got %0d want 2", pf_if.q_level); end
    checks++; if (pf_if.fetch_req !== 1'b0) begin errors++; $display("FAIL basic_req_dropped: got %b want 0", pf_if.fetch_req); end
    pop1();
    checks++; if (pf_if.ins_data !== 16'h1234) begin errors++; $display("FAIL basic_lo_word: got %h want 1234", pf_if.ins_data); end
    checks++; if (pf_if.ins_pc !== 24'h000102) begin errors++; $display("FAIL basic_lo_pc: got %h want 000102", pf_if.ins_pc); end
    checks++; if (pf_if.q_level !== 3'd1) begin errors++; $display("FAIL basic_level1: got %0d want 1", pf_if.q_level); end
    checks++; if (pf_if.fetch_req !== 1'b1 || pf_if.fetch_addr !== 24'h000104) begin errors++; $display("FAIL basic_next_req: got req=%b addr=%h want req=1 addr=000104", pf_if.fetch_req, pf_if.fetch_addr); end
  endtask

  task automatic test_skip_hi();
    do_reset();
    jump(24'h000102);
    checks++; if (pf_if.fetch_addr !== 24'h000100 || pf_if.ins_pc !== 24'h000102) begin errors++; $display("FAIL skip_targets: got addr=%h pc=%h want 000100/000102", pf_if.fetch_addr, pf_if.ins_pc); end
    tick();
    checks++; if (pf_if.fetch_req !== 1'b1) begin errors++; $display("FAIL skip_req: got %b want 1", pf_if.fetch_req); end
    ack(32'h98761234);
    checks++; if (pf_if.q_level !== 3'd1) begin errors++; $display("FAIL skip_level: got %0d want 1", pf_if.q_level); end
    checks++; if (pf_if.ins_data !== 16'h1234) begin errors++; $display("FAIL skip_word: got %h want 1234", pf_if.ins_data); end
    checks++; if (pf_if.ins_pc !== 24'h000102) begin errors++; $display("FAIL skip_pc: got %h want 000102", pf_if.ins_pc); end
    checks++; if (pf_if.fetch_addr !== 24'h000104) begin errors++; $display("FAIL skip_next_addr: got %h want 000104", pf_if.fetch_addr); end
    tick();
    ack(32'h55556666);
    // skip_hi must be cleared: both halves of the second longword enter.
    checks++; if (pf_if.q_level !== 3'd3) begin errors++; $display("FAIL skip_cleared_level: got %0d want 3", pf_if.q_level); end
  endtask

  task automatic test_full();
    do_reset();
    jump(24'h000200);
    tick();
    ack(32'h11112222);
    tick();
    checks++; if (pf_if.fetch_req !== 1'b1 || pf_if.fetch_addr !== 24'h000204) begin errors++; $display("FAIL full_second_req: got req=%b addr=%h want 1/000204", pf_if.fetch_req, pf_if.fetch_addr); end
    ack(32'h33334444);
    tick();
    checks++; if (pf_if.q_level !== 3'd4) begin errors++; $display("FAIL full_level4: got %0d want 4", pf_if.q_level); end
    checks++; if (pf_if.fetch_req !== 1'b0) begin errors++; $display("FAIL full_no_req: got %b want 0", pf_if.fetch_req); end
    pop1();
    tick();
    checks++; if (pf_if.q_level !== 3'd3 || pf_if.fetch_req !== 1'b0) begin errors++; $display("FAIL full_one_free: got level=%0d req=%b want 3/0", pf_if.q_level, pf_if.fetch_req); end
    checks++; if (pf_if.ins_data !== 16'h2222 || pf_if.ins_pc !== 24'h000202) begin errors++; $display("FAIL full_head: got %h@%h want 2222@000202", pf_if.ins_data, pf_if.ins_pc); end
    pop1();
    tick();
    checks++; if (pf_if.fetch_req !== 1'b1 || pf_if.fetch_addr !== 24'h000208) begin errors++; $display("FAIL full_two_free_req: got req=%b addr=%h want 1/000208", pf_if.fetch_req, pf_if.fetch_addr); end
    checks++; if (pf_if.ins_data !== 16'h3333 || pf_if.q_level !== 3'd2) begin errors++; $display("FAIL full_after_pops: got %h level=%0d want 3333/2", pf_if.ins_data, pf_if.q_level); end
  endtask

  task automatic test_stale();
    do_reset();
    jump(24'h000300);
    tick();
    checks++; if (pf_if.fetch_req !== 1'b1) begin errors++; $display("FAIL stale_req: got %b want 1", pf_if.fetch_req); end
    jump(24'h000400);
    checks++; if (pf_if.fetch_req !== 1'b0 || pf_if.fetch_addr !== 24'h000400) begin errors++; $display("FAIL stale_enter: got req=%b addr=%h want 0/000400", pf_if.fetch_req, pf_if.fetch_addr); end
    tick();
    checks++; if (pf_if.fetch_req !== 1'b0) begin errors++; $display("FAIL stale_hold: got %b want 0", pf_if.fetch_req); end
    ack(32'hDEADBEEF);
    checks++; if (pf_if.q_level !== 3'd0 || pf_if.insrdy !== 1'b0) begin errors++; $display("FAIL stale_dropped: got level=%0d rdy=%b want 0/0", pf_if.q_level, pf_if.insrdy); end
    tick();
    checks++; if (pf_if.fetch_req !== 1'b1 || pf_if.fetch_addr !== 24'h000400) begin errors++; $display("FAIL stale_reissue: got req=%b addr=%h want 1/000400", pf_if.fetch_req, pf_if.fetch_addr); end
    // Jump with same-cycle ack: data discarded, next cycle IDLE.
    pf_if.pc_load    = 1'b1;
    pf_if.pc_new     = 24'h000500;
    pf_if.fetch_ack  = 1'b1;
    pf_if.fetch_data = 32'hCAFEF00D;
    tick();
    pf_if.pc_load   = 1'b0;
    pf_if.fetch_ack = 1'b0;
    checks++; if (pf_if.q_level !== 3'd0 || pf_if.fetch_addr !== 24'h000500) begin errors++; $display("FAIL load_with_ack: got level=%0d addr=%h want 0/000500", pf_if.q_level, pf_if.fetch_addr); end
    tick();
    checks++; if (pf_if.fetch_req !== 1'b1) begin errors++; $display("FAIL load_with_ack_req: got %b want 1", pf_if.fetch_req); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    jump(24'hFFFFFC);
    tick();
    ack(32'hAAAA5555);
    checks++; if (pf_if.fetch_addr !== 24'h000000) begin errors++; $display("FAIL wrap_addr: got %h want 000000", pf_if.fetch_addr); end
    tick();
    checks++; if (pf_if.fetch_req !== 1'b1) begin errors++; $display("FAIL b2b_req: got %b want 1", pf_if.fetch_req); end
    pf_if.romold = 1'b1;
    ack(32'h66667777);
    pf_if.romold = 1'b0;
    checks++; if (pf_if.q_level !== 3'd3) begin errors++; $display("FAIL b2b_level: got %0d want 3", pf_if.q_level); end
    checks++; if (pf_if.ins_data !== 16'h5555 || pf_if.ins_pc !== 24'hFFFFFE) begin errors++; $display("FAIL b2b_head: got %h@%h want 5555@fffffe", pf_if.ins_data, pf_if.ins_pc); end
    checks++; if (pf_if.fetch_addr !== 24'h000004) begin errors++; $display("FAIL b2b_addr: got %h want 000004", pf_if.fetch_addr); end
    pop1();
    checks++; if (pf_if.ins_pc !== 24'h000000 || pf_if.ins_data !== 16'h6666) begin errors++; $display("FAIL pc_wrap: got %h@%h want 6666@000000", pf_if.ins_data, pf_if.ins_pc); end
  endtask

  task automatic test_go_low();
    do_reset();
    jump(24'h000500);
    tick();
    pf_if.go = 1'b0;
    tick();
    checks++; if (pf_if.fetch_req !== 1'b1) begin errors++; $display("FAIL golow_req_held: got %b want 1", pf_if.fetch_req); end
    ack(32'h01020304);
    checks++; if (pf_if.q_level !== 3'd2 || pf_if.ins_data !== 16'h0102) begin errors++; $display("FAIL golow_push: got level=%0d data=%h want 2/0102", pf_if.q_level, pf_if.ins_data); end
    tick();
    tick();
    checks++; if (pf_if.fetch_req !== 1'b0) begin errors++; $display("FAIL golow_no_req: got %b want 0", pf_if.fetch_req); end
    pop1();
    checks++; if (pf_if.q_level !== 3'd1 || pf_if.ins_data !== 16'h0304) begin errors++; $display("FAIL golow_pop: got level=%0d data=%h want 1/0304", pf_if.q_level, pf_if.ins_data); end
    pf_if.go = 1'b1;
    tick();
    checks++; if (pf_if.fetch_req !== 1'b1 || pf_if.fetch_addr !== 24'h000504) begin errors++; $display("FAIL golow_resume: got req=%b addr=%h want 1/000504", pf_if.fetch_req, pf_if.fetch_addr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skip_hi();
    test_full();
    test_stale();
    test_back_to_back();
    test_go_low();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
